// File: rtl/seg7_display.sv
// seg7_display
// Multi-digit seven-segment display driver. A value captured on i_load is
// converted to hexadecimal nibbles (one cycle) or to BCD by shift-add-3
// (one bit per cycle, MSB first). The result is then encoded into active-low
// segment patterns with sign, leading-zero blanking and overflow handling.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset
//   i_load       start a conversion (only honoured while idle)
//   i_value      value to display, captured on an accepted load
//   i_is_signed  treat i_value as two's complement
//   i_dec_mode   1 = decimal, 0 = hexadecimal
//   i_blank_lz   1 = blank leading zeros
//   o_busy       conversion in progress
//   o_done       one-cycle pulse when o_hex_out/o_overflow are updated
//   o_overflow   last result did not fit on the display
//   o_hex_out    digit i at [7i+6:7i], digit 0 rightmost, segment j on bit j
//
// state    | meaning
// S_IDLE   | waiting for i_load
// S_CONV   | hex: single pass-through cycle; decimal: WIDTH dabble steps
// S_UPDATE | encode digits, write outputs, pulse o_done
module seg7_display #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_value,
  input  logic                  i_is_signed,
  input  logic                  i_dec_mode,
  input  logic                  i_blank_lz,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [7*DIGITS-1:0]   o_hex_out
);

  // ceil(WIDTH * log10(2)); the product is never an exact integer
  localparam int BCD_DIGITS = (WIDTH * 30103 + 99999) / 100000;
  // digit store must hold both the BCD result and the zero-extended nibbles
  localparam int ND = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
  localparam int BW = 4 * ND;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_UPDATE
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_shift;
  logic [BW-1:0]        r_bcd;
  logic                 r_neg;
  logic                 r_dec;
  logic                 r_blank;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;
  logic [7*DIGITS-1:0]  r_hex;

  logic                 w_is_neg;
  logic [WIDTH-1:0]     w_mag;
  logic [BW-1:0]        w_dab;
  int                   w_sig;
  logic                 w_ovf;
  logic [7*DIGITS-1:0]  w_hex;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // most negative input negates to itself, which read unsigned is 2^(WIDTH-1)
  assign w_is_neg = i_is_signed & i_value[WIDTH-1];
  assign w_mag    = w_is_neg ? ((~i_value) + WIDTH'(1)) : i_value;

  always_comb begin
    w_dab = r_bcd;
    for (int i = 0; i < ND; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_dab[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (i_load) w_state_nxt = S_CONV;
      S_CONV:   if (!r_dec || (r_cnt == '0)) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Digits above the display width are folded into w_sig, so a single
  // compare catches both "too many digits" and "no room for the minus".
  always_comb begin
    w_sig = 1;
    for (int i = 0; i < ND; i++) begin
      if (r_bcd[4*i +: 4] != 4'd0) w_sig = i + 1;
    end
    w_ovf = (w_sig + int'(r_neg)) > DIGITS;
    w_hex = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_ovf)
        w_hex[7*i +: 7] = SEG_E;
      else if (i < w_sig)
        w_hex[7*i +: 7] = glyph(r_bcd[4*i +: 4]);
      else if (r_neg && ((r_blank && (i == w_sig)) || (!r_blank && (i == DIGITS-1))))
        w_hex[7*i +: 7] = SEG_MINUS;
      else if (r_blank)
        w_hex[7*i +: 7] = SEG_BLANK;
      else
        w_hex[7*i +: 7] = glyph(4'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_bcd   <= '0;
      r_neg   <= 1'b0;
      r_dec   <= 1'b0;
      r_blank <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_hex   <= '1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_neg   <= w_is_neg;
            r_dec   <= i_dec_mode;
            r_blank <= i_blank_lz;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH-1);
            if (i_dec_mode) begin
              r_shift <= w_mag;
              r_bcd   <= '0;
            end else begin
              r_shift <= '0;
              r_bcd   <= BW'(w_mag);
            end
          end
        end
        S_CONV: begin
          if (r_dec) begin
            r_bcd   <= {w_dab[BW-2:0], r_shift[WIDTH-1]};
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        S_UPDATE: begin
          r_hex  <= w_hex;
          r_ovf  <= w_ovf;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_overflow = r_ovf;
  assign o_hex_out  = r_hex;

endmodule

// File: tb/tb_seg7_display.sv
// Testbench for seg7_display (DIGITS=4, WIDTH=16).
module tb_seg7_display;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 16;
  localparam int HW     = 7*DIGITS;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [WIDTH-1:0] value;
  logic            is_signed;
  logic            dec_mode;
  logic            blank_lz;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [HW-1:0]   hex_out;

  int              checks = 0;
  int              errors = 0;
  logic [HW-1:0]   prev_hex;
  logic            prev_ovf;
  logic [HW-1:0]   got;

  always #5 clk = ~clk;

  seg7_display #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load      (load),
    .i_value     (value),
    .i_is_signed (is_signed),
    .i_dec_mode  (dec_mode),
    .i_blank_lz  (blank_lz),
    .o_busy      (busy),
    .o_done      (done),
    .o_overflow  (overflow),
    .o_hex_out   (hex_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Digits come from repeated division in the chosen base.
  function automatic logic [HW-1:0] model(input int v, input bit sg, input bit dec,
                                          input bit bl, output bit ovf);
    logic [HW-1:0] h;
    int mag, neg, base, sig, minus_pos;
    int d [8];
    neg  = (sg && v >= (1 << (WIDTH-1))) ? 1 : 0;
    mag  = neg ? ((1 << WIDTH) - v) : v;
    base = dec ? 10 : 16;
    for (int i = 0; i < 8; i++) begin
      d[i] = mag % base;
      mag  = mag / base;
    end
    sig = 1;
    for (int i = 0; i < 8; i++) if (d[i] != 0) sig = i + 1;
    ovf = (sig + neg) > DIGITS;
    minus_pos = bl ? sig : DIGITS-1;
    for (int i = 0; i < DIGITS; i++) begin
      if (ovf)                          h[7*i +: 7] = 7'b0000110;
      else if (i < sig)                 h[7*i +: 7] = seg_of(d[i]);
      else if (neg && i == minus_pos)   h[7*i +: 7] = 7'b0111111;
      else if (bl)                      h[7*i +: 7] = 7'b1111111;
      else                              h[7*i +: 7] = seg_of(0);
    end
    return h;
  endfunction

  // One conversion; load is raised before edge k. With poke set, a second
  // load is presented at edge k+5 and must be ignored.
  task automatic run_conv(input int v, input bit sg, input bit dec, input bit bl,
                          input bit poke, output logic [HW-1:0] obs);
    logic [HW-1:0] eh;
    bit eo;
    int lat;
    eh  = model(v, sg, dec, bl, eo);
    lat = dec ? WIDTH+1 : 2;
    value = WIDTH'(v); is_signed = sg; dec_mode = dec; blank_lz = bl; load = 1'b1;
    tick;
    load = 1'b0;
    value = WIDTH'($urandom_range(0, 65535));
    is_signed = 1'($urandom); dec_mode = 1'($urandom); blank_lz = 1'($urandom);
    check("busy_rise", busy, 1);
    check("done_low_k", done, 0);
    for (int c = 1; c < lat; c++) begin
      if (poke && c == 5) load = 1'b1;
      tick;
      load = 1'b0;
      check("busy_hold", busy, 1);
      check("done_early", done, 0);
      check("hex_hold", hex_out, prev_hex);
      check("ovf_hold", overflow, prev_ovf);
    end
    tick;
    check("done_pulse", done, 1);
    check("busy_fall", busy, 0);
    check("hex_out", hex_out, eh);
    check("overflow", overflow, eo);
    prev_hex = eh;
    prev_ovf = eo;
    obs = hex_out;
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; is_signed = 1'b0; dec_mode = 1'b0; blank_lz = 1'b0;
    tick; tick;
    check("rst_hex", hex_out, {HW{1'b1}});
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    prev_hex = {HW{1'b1}};
    prev_ovf = 1'b0;
    tick;

    run_conv(16'h1A3F, 0, 0, 0, 0, got);
    check("plan_hex_1a3f", got, {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110});
    run_conv(1234, 0, 1, 1, 0, got);
    check("plan_dec_1234", got, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001});
    run_conv(16'hFFFB, 1, 1, 1, 0, got);
    check("plan_neg5_blank", got, {7'b1111111, 7'b1111111, 7'b0111111, 7'b0010010});
    run_conv(16'hFFFB, 1, 1, 0, 0, got);
    check("plan_neg5_zeros", got, {7'b0111111, 7'b1000000, 7'b1000000, 7'b0010010});
    run_conv(0, 0, 1, 1, 1, got);
    check("plan_zero_blank", got, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000});
    tick;
    check("poke_not_queued_busy", busy, 0);
    check("poke_single_done", done, 0);
    run_conv(12345, 0, 1, 0, 0, got);
    check("plan_ovf_12345", got, {DIGITS{7'b0000110}});
    run_conv(16'hFB2E, 1, 1, 1, 0, got);
    check("plan_ovf_m1234", got, {DIGITS{7'b0000110}});
    run_conv(16'h8000, 1, 0, 0, 0, got);
    check("plan_ovf_hex8000", got, {DIGITS{7'b0000110}});

    // abort a decimal conversion; reset is sampled at edge k+8
    value = 16'd999; is_signed = 1'b0; dec_mode = 1'b1; blank_lz = 1'b0; load = 1'b1;
    tick;
    load = 1'b0;
    for (int c = 1; c < 8; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_hex", hex_out, {HW{1'b1}});
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ovf", overflow, 0);
    prev_hex = {HW{1'b1}};
    prev_ovf = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick;
      check("abort_no_done", done, 0);
    end
    run_conv(4321, 0, 1, 0, 0, got);

    // corners: extremes in every mode
    run_conv(16'h8000, 1, 1, 1, 0, got);
    run_conv(16'hFFFF, 0, 0, 1, 0, got);
    run_conv(16'hFFFF, 1, 0, 0, 0, got);
    run_conv(9999, 0, 1, 1, 0, got);
    run_conv(10000, 0, 1, 1, 0, got);
    run_conv(16'hF001, 1, 0, 1, 0, got);
    run_conv(0, 0, 0, 0, 0, got);

    for (int n = 0; n < 40; n++) begin
      int v;
      v = (n % 3 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
      run_conv(v, 1'($urandom), 1'($urandom), 1'($urandom), 0, got);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seg7_display.md
# seg7_display

Multi-digit seven-segment display driver: accepts a binary value on a `load` strobe, converts it to hexadecimal or decimal digits, and drives `DIGITS` active-low seven-segment outputs. Decimal conversion is a sequential shift-add-3 (double-dabble), one bit per cycle. The block adds signed display, leading-zero blanking and overflow indication. It sits between the datapath's result register and the board's display pins, replacing per-digit single-nibble decoders.

## Interface
- `DIGITS`, 4: number of display digits, ≥ 2.
- `WIDTH`, 16: input value width, 2 ≤ `WIDTH` ≤ 4·`DIGITS`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `load` input 1: start conversion, sampled only in IDLE.
- `value` input `WIDTH`: value to display, captured on an accepted `load`.
- `is_signed` input 1: treat `value` as two's complement, captured with `value`.
- `dec_mode` input 1: 1 = decimal, 0 = hexadecimal, captured.
- `blank_lz` input 1: 1 = blank leading zeros, captured.
- `busy` output 1: conversion in progress.
- `done` output 1: one-cycle pulse when `hex_out` is updated.
- `overflow` output 1: last result did not fit in the display, held until the next update.
- `hex_out` output 7·`DIGITS`: digit i is `hex_out[7i+6:7i]`, digit 0 rightmost. Bit j drives segment j, active-low: 0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.

## Operation
- States: IDLE → CONV → UPDATE → IDLE.
- IDLE: on `load`=1, capture `value` and the three flags, then go to CONV.
  - If `is_signed` and the MSB is 1, set `neg`=1 and take the magnitude as the `WIDTH`-bit two's complement negation, read unsigned. The most negative value gives magnitude 2^(`WIDTH`−1).
- CONV, hex mode: one cycle. The digits are the magnitude's nibbles, zero-extended.
- CONV, decimal mode: `WIDTH` cycles of double-dabble, MSB first.
  - Per cycle: add 3 to every BCD digit ≥ 5, then shift left one bit.
  - The internal BCD register holds `BCD_DIGITS` = ceil(`WIDTH`·log10 2) digits, computed as a localparam.
- UPDATE: one cycle. Computes the encoded output, writes `hex_out` and `overflow`, pulses `done`, and returns to IDLE.
  - `sig` = index of the most significant nonzero digit + 1, minimum 1. A value of zero still shows a "0" in digit 0.
  - Overflow occurs when `sig` + `neg` > `DIGITS`, or (decimal mode) any BCD digit at index ≥ `DIGITS` is nonzero. On overflow every digit shows E (0000110) and `overflow`=1.
  - Otherwise each digit at index < `sig` shows its glyph.
  - Digits at index ≥ `sig` show blank (1111111) when `blank_lz`=1, or glyph "0" when `blank_lz`=0.
  - Minus (0111111) replaces digit `sig` when `blank_lz`=1, or digit `DIGITS`−1 when `blank_lz`=0.
- Glyphs:
  - Digits 0–9: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000.
  - Letters A–F: A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- `load` while `busy`=1 is ignored and not queued. `hex_out` holds its previous content throughout a conversion.

## Timing
- Reset values: `hex_out` all 1 (all digits blank), `busy`=0, `done`=0, `overflow`=0, state IDLE.
- `rst` mid-conversion aborts it at the same edge and applies the reset values; no `done` pulse follows.
- Let k be the edge that accepts `load`.
  - `busy` is 1 after edge k.
  - Hex mode: `hex_out`, `overflow` and `done`=1 become valid after edge k+2.
  - Decimal mode: the same become valid after edge k+`WIDTH`+1.
  - `busy` falls at the same edge that raises `done`. `done` falls at the next edge.
- `load` asserted in the cycle where `done`=1 is accepted: the block is already in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use `DIGITS`=4, `WIDTH`=16; digits are listed 3..0.
- Hex, unsigned, `blank_lz`=0, `value`=0x1A3F → `hex_out` = {1111001, 0001000, 0110000, 0001110}, `done` after k+2, `overflow`=0.
- Decimal, unsigned, `blank_lz`=1, `value`=1234 → {1111001, 0100100, 0110000, 0011001} after edge k+17. `busy` is high for exactly 17 cycles.
- Decimal, signed, `value`=0xFFFB (−5):
  - `blank_lz`=1 → {1111111, 1111111, 0111111, 0010010}.
  - `blank_lz`=0 → {0111111, 1000000, 1000000, 0010010}.
- Overflow cases, each → all digits 0000110, `overflow`=1:
  - decimal unsigned 12345;
  - decimal signed −1234 (0xFB2E);
  - hex signed 0x8000.
- Zero with `blank_lz`=1 → {1111111, 1111111, 1111111, 1000000}. A second `load` pulsed at k+5 during a decimal conversion is ignored: exactly one `done`.
- `rst` asserted at k+8 of a decimal conversion → all outputs at reset values next cycle, no `done`. A new `load` afterwards converts normally.
